cmv_frame_capture: RTL

Parametrised successor to the CMV300 capture path: samples the sensor pixel bus on `i_clk`, tracks lines and columns, and crops a runtime region of interest (ROI). It packs the cropped pixels into wide words for a downstream FIFO, pads each frame to a whole number of FIFO blocks, and flags overflow and malformed lines. It sits between the sensor pins and the frame FIFO, under the system control FSM.

---
 rtl/cmv_frame_capture.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cmv_frame_capture.sv
// Sensor pixel capture: tracks lines/columns, crops a runtime ROI, packs kept pixels
// into wide FIFO words and pads each frame to a whole number of FIFO blocks.
module cmv_frame_capture #(
    parameter int DATA_W          = 10,
    parameter int OUT_BITS        = 8,
    parameter int PACK            = 4,
    parameter int COLS            = 648,
    parameter int PAD_BLOCK_WORDS = 256
) (
    input  logic                     i_clk,
    input  logic                     line_counter_rst,
    input  logic                     i_arm,
    input  logic [9:0]               i_rows,
    input  logic [9:0]               i_roi_row_first,
    input  logic [9:0]               i_roi_row_last,
    input  logic [9:0]               i_roi_col_first,
    input  logic [9:0]               i_roi_col_last,
    input  logic                     i_lval,
    input  logic                     i_dval,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_wr_full,
    output logic                     o_wr_en,
    output logic [OUT_BITS*PACK-1:0] o_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [9:0]               o_line_count,
    output logic                     o_err_overflow,
    output logic                     o_err_line
);
    localparam int WORD_W = OUT_BITS * PACK;
    localparam int PCNT_W = $clog2(PACK + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_CAPTURE,
        S_FLUSH,
        S_PAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          rows_q, rows_d;
    logic [9:0]          roi_rf_q, roi_rf_d, roi_rl_q, roi_rl_d;
    logic [9:0]          roi_cf_q, roi_cf_d, roi_cl_q, roi_cl_d;
    logic                lval_q, lval_d, dval_q, dval_d;
    logic [OUT_BITS-1:0] pix_q, pix_d;
    logic                lval_prev_q, lval_prev_d;
    logic                fall_q, fall_d;
    logic [15:0]         col_q, col_d;
    logic [9:0]          line_cnt_q, line_cnt_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [PCNT_W-1:0]   pack_cnt_q, pack_cnt_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                wr_en_q, wr_en_d;
    logic [31:0]         word_cnt_q, word_cnt_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_line_q, err_line_d;

    logic                rise;
    logic                emit;
    logic                keep;
    logic                row_in;
    logic                col_in;
    logic [10:0]         row_cur;
    logic [15:0]         col_cur;
    logic [PCNT_W-1:0]   lane;
    logic [WORD_W-1:0]   pack_base;

    // Only the pixel MSBs are kept; the remaining bits are discarded on purpose.
    logic unused_data_bits;
    assign unused_data_bits = ^i_data;

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        roi_rf_d    = roi_rf_q;
        roi_rl_d    = roi_rl_q;
        roi_cf_d    = roi_cf_q;
        roi_cl_d    = roi_cl_q;
        lval_d      = i_lval;
        dval_d      = i_dval;
        pix_d       = i_data[DATA_W-1 -: OUT_BITS];
        lval_prev_d = lval_q;
        fall_d      = 1'b0;
        col_d       = col_q;
        line_cnt_d  = line_cnt_q;
        pack_d      = pack_q;
        pack_cnt_d  = pack_cnt_q;
        out_data_d  = out_data_q;
        wr_en_d     = 1'b0;
        word_cnt_d  = word_cnt_q;
        err_ovf_d   = err_ovf_q;
        err_line_d  = err_line_q;

        rise      = lval_q & ~lval_prev_q;
        col_cur   = rise ? 16'd0 : col_q;
        // A line end still in the count pipeline already belongs to the next row.
        row_cur   = {1'b0, line_cnt_q} + {10'd0, fall_q};
        row_in    = (row_cur < {1'b0, rows_q}) &&
                    (row_cur >= {1'b0, roi_rf_q}) && (row_cur <= {1'b0, roi_rl_q});
        col_in    = (col_cur >= {6'd0, roi_cf_q}) && (col_cur <= {6'd0, roi_cl_q});
        keep      = lval_q & dval_q & row_in & col_in;
        emit      = (pack_cnt_q == PCNT_W'(PACK));
        lane      = emit ? '0 : pack_cnt_q;
        pack_base = emit ? '0 : pack_q;

        case (state_q)
            S_IDLE: begin
                if (i_arm) begin
                    rows_d     = i_rows;
                    roi_rf_d   = i_roi_row_first;
                    roi_rl_d   = i_roi_row_last;
                    roi_cf_d   = i_roi_col_first;
                    roi_cl_d   = i_roi_col_last;
                    err_ovf_d  = 1'b0;
                    err_line_d = 1'b0;
                    line_cnt_d = '0;
                    word_cnt_d = '0;
                    pack_d     = '0;
                    pack_cnt_d = '0;
                    state_d    = (i_rows == 10'd0) ? S_FLUSH : S_SYNC;
                end
            end
            S_SYNC: begin
                if (!lval_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                col_d  = col_cur + 16'(lval_q & dval_q);
                fall_d = lval_prev_q & ~lval_q;
                // A full word waits one cycle in the pack register before it leaves.
                pack_d = pack_base;
                for (int k = 0; k < PACK; k++) begin
                    if (keep && (lane == PCNT_W'(k))) begin
                        pack_d[k*OUT_BITS +: OUT_BITS] = pix_q;
                    end
                end
                pack_cnt_d = lane + PCNT_W'(keep);
                if (emit) begin
                    if (i_wr_full) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        wr_en_d    = 1'b1;
                        out_data_d = pack_q;
                        word_cnt_d = word_cnt_q + 32'd1;
                    end
                end
                if (fall_q) begin
                    if (col_q != 16'(COLS)) begin
                        err_line_d = 1'b1;
                    end
                    line_cnt_d = line_cnt_q + 10'd1;
                end
                if (line_cnt_q == rows_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pack_cnt_q == '0) begin
                    state_d = S_PAD;
                end else if (!i_wr_full) begin
                    wr_en_d    = 1'b1;
                    out_data_d = pack_q;
                    word_cnt_d = word_cnt_q + 32'd1;
                    pack_d     = '0;
                    pack_cnt_d = '0;
                    state_d    = S_PAD;
                end
            end
            S_PAD: begin
                if ((word_cnt_q % 32'(PAD_BLOCK_WORDS)) == 32'd0) begin
                    state_d = S_DONE;
                end else if (!i_wr_full) begin
                    wr_en_d    = 1'b1;
                    out_data_d = '0;
                    word_cnt_d = word_cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge line_counter_rst) begin
        if (line_counter_rst) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            roi_rf_q    <= '0;
            roi_rl_q    <= '0;
            roi_cf_q    <= '0;
            roi_cl_q    <= '0;
            lval_q      <= 1'b0;
            dval_q      <= 1'b0;
            pix_q       <= '0;
            lval_prev_q <= 1'b0;
            fall_q      <= 1'b0;
            col_q       <= '0;
            line_cnt_q  <= '0;
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            out_data_q  <= '0;
            wr_en_q     <= 1'b0;
            word_cnt_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_line_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            roi_rf_q    <= roi_rf_d;
            roi_rl_q    <= roi_rl_d;
            roi_cf_q    <= roi_cf_d;
            roi_cl_q    <= roi_cl_d;
            lval_q      <= lval_d;
            dval_q      <= dval_d;
            pix_q       <= pix_d;
            lval_prev_q <= lval_prev_d;
            fall_q      <= fall_d;
            col_q       <= col_d;
            line_cnt_q  <= line_cnt_d;
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            out_data_q  <= out_data_d;
            wr_en_q     <= wr_en_d;
            word_cnt_q  <= word_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_line_q  <= err_line_d;
        end
    end

    assign o_wr_en        = wr_en_q;
    assign o_wr_data      = out_data_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE);
    assign o_line_count   = line_cnt_q;
    assign o_err_overflow = err_ovf_q;
    assign o_err_line     = err_line_q;

endmodule
